// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder: FSM states, word
// geometry and the request address check.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int DATA_W     = 32;

  // A request is bad when it is not word-aligned or lands past the array.
  function automatic logic addr_bad(input logic [DATA_W-1:0] addr,
                                    input int unsigned depth_words);
    logic [DATA_W:0] limit;
    limit = {1'b0, DATA_W'(depth_words)} << 2;
    return (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Core-side request/response bus of the memory responder.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic              rd_req;
  logic              wr_req;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              ack;
  logic [DATA_W-1:0] rd_data;
  logic              err;
  logic              busy;

  modport master (
    output rd_req, wr_req, addr, wr_data,
    input  ack, rd_data, err, busy
  );

  modport slave (
    input  rd_req, wr_req, addr, wr_data,
    output ack, rd_data, err, busy
  );

endinterface

// File: rtl/mem_responder_array.sv
// Single-port word storage with one write port and a registered read.
// Contents are deliberately not reset.
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [DATA_W-1:0]              wdata,
  output logic [DATA_W-1:0]              rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
    rdata <= mem_q[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one read/write at a time and answers with a
// single ack pulse LATENCY cycles after acceptance.
//
// state | meaning
// IDLE  | waiting for rd_req/wr_req; request captured on acceptance
// WAIT  | latency countdown in progress
// RESP  | ack cycle; write commits at the end of this cycle
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rd_hold_q, rd_hold_d;

  logic [IDX_W-1:0]  arr_idx;
  logic              arr_we;
  logic [DATA_W-1:0] arr_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      rd_hold_q <= rd_hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    wr_d      = wr_q;
    err_d     = err_q;
    rd_hold_d = rd_hold_q;
    case (state_q)
      IDLE: begin
        if (bus.rd_req || bus.wr_req) begin
          idx_d   = bus.addr[IDX_W+1:2];
          data_d  = bus.wr_data;
          wr_d    = bus.wr_req;
          err_d   = addr_bad(bus.addr, DEPTH_WORDS) || (bus.rd_req && bus.wr_req);
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (err_q) begin
          rd_hold_d = '0;
        end else if (!wr_q) begin
          rd_hold_d = arr_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // In IDLE the array is addressed straight from the bus so the read word is
  // already registered at the acceptance edge; this is what makes LATENCY=1 work.
  assign arr_idx = (state_q == IDLE) ? bus.addr[IDX_W+1:2] : idx_q;
  assign arr_we  = (state_q == RESP) && wr_q && !err_q;

  mem_responder_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (arr_idx),
    .wdata (data_q),
    .rdata (arr_rdata)
  );

  assign bus.ack     = (state_q == RESP);
  assign bus.err     = (state_q == RESP) && err_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.rd_data = (state_q != RESP) ? rd_hold_q :
                       err_q             ? '0        :
                       wr_q              ? rd_hold_q : arr_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=4 / 256-word build and a LATENCY=1 /
// 16-word build, checked every cycle against a request-level model.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int L0 = 4;
  localparam int D0 = 256;
  localparam int L1 = 1;
  localparam int D1 = 16;
  localparam int LATS   [2] = '{L0, L1};
  localparam int DEPTHS [2] = '{D0, D1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if if0 ();
  mem_responder_if if1 ();

  mem_responder #(.DEPTH_WORDS(D0), .LATENCY(L0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  mem_responder #(.DEPTH_WORDS(D1), .LATENCY(L1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  logic        in_rd [2];
  logic        in_wr [2];
  logic [31:0] in_a  [2];
  logic [31:0] in_wd [2];
  logic        o_ack [2];
  logic        o_err [2];
  logic        o_busy[2];
  logic [31:0] o_rd  [2];

  assign in_rd[0] = if0.rd_req;   assign in_rd[1] = if1.rd_req;
  assign in_wr[0] = if0.wr_req;   assign in_wr[1] = if1.wr_req;
  assign in_a[0]  = if0.addr;     assign in_a[1]  = if1.addr;
  assign in_wd[0] = if0.wr_data;  assign in_wd[1] = if1.wr_data;
  assign o_ack[0] = if0.ack;      assign o_ack[1] = if1.ack;
  assign o_err[0] = if0.err;      assign o_err[1] = if1.err;
  assign o_busy[0]= if0.busy;     assign o_busy[1]= if1.busy;
  assign o_rd[0]  = if0.rd_data;  assign o_rd[1]  = if1.rd_data;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Request-level model: 'left' counts the busy cycles still to go after an
  // accepted request; the response is due in the cycle where left == 1.
  int          left  [2] = '{0, 0};
  bit          cerr  [2];
  bit          cwr   [2];
  int          cidx  [2];
  logic [31:0] cdata [2];
  logic [31:0] hold  [2] = '{32'h0, 32'h0};
  bit          hk    [2] = '{1'b1, 1'b1};
  logic [31:0] mm    [2][256];
  bit          mv    [2][256];

  always @(posedge clk or negedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        left[d] <= 0;
        hold[d] <= 32'h0;
        hk[d]   <= 1'b1;
      end else if (left[d] > 0) begin
        if (left[d] == 1) begin
          if (cerr[d]) begin
            hold[d] <= 32'h0;
            hk[d]   <= 1'b1;
          end else if (cwr[d]) begin
            mm[d][cidx[d]] <= cdata[d];
            mv[d][cidx[d]] <= 1'b1;
          end else begin
            hold[d] <= mm[d][cidx[d]];
            hk[d]   <= mv[d][cidx[d]];
          end
        end
        left[d] <= left[d] - 1;
      end else if (in_rd[d] || in_wr[d]) begin
        left[d]  <= LATS[d];
        cerr[d]  <= (in_a[d] % 4 != 0) || (in_a[d] >= 32'(DEPTHS[d] * 4)) ||
                    (in_rd[d] && in_wr[d]);
        cwr[d]   <= in_wr[d];
        cidx[d]  <= int'((in_a[d] / 4) % 32'(DEPTHS[d]));
        cdata[d] <= in_wd[d];
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic        e_ack;
      logic [31:0] e_rd;
      bit          e_k;
      e_ack = (left[d] == 1);
      if (e_ack) begin
        e_rd = cerr[d] ? 32'h0 : (cwr[d] ? hold[d] : mm[d][cidx[d]]);
        e_k  = cerr[d] ? 1'b1  : (cwr[d] ? hk[d]   : mv[d][cidx[d]]);
      end else begin
        e_rd = hold[d];
        e_k  = hk[d];
      end
      chk($sformatf("d%0d ack", d),  32'(o_ack[d]),  32'(e_ack));
      chk($sformatf("d%0d err", d),  32'(o_err[d]),  32'(e_ack && cerr[d]));
      chk($sformatf("d%0d busy", d), 32'(o_busy[d]), 32'(left[d] > 0));
      if (e_k) chk($sformatf("d%0d rd_data", d), o_rd[d], e_rd);
    end
  end

  task automatic drive(input int d, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      if0.rd_req = rd; if0.wr_req = wr; if0.addr = a; if0.wr_data = wd;
    end else begin
      if1.rd_req = rd; if1.wr_req = wr; if1.addr = a; if1.wr_data = wd;
    end
  endtask

  // One request on an idle DUT; returns latency (-1 on timeout), err, rd_data.
  task automatic do_req(input int d, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic e, output logic [31:0] rdv);
    @(negedge clk);
    drive(d, rd, wr, a, wd);
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
    lat = 1;
    while (!o_ack[d] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    e   = o_err[d];
    rdv = o_rd[d];
    if (!o_ack[d]) lat = -1;
  endtask

  task automatic req_chk(input string nm, input int d, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic exp_err, input bit check_rd, input logic [31:0] exp_rd);
    int          lat;
    logic        e;
    logic [31:0] rdv;
    do_req(d, rd, wr, a, wd, lat, e, rdv);
    chk({nm, " latency"}, 32'(lat), 32'(LATS[d]));
    chk({nm, " err"}, 32'(e), 32'(exp_err));
    if (check_rd) chk({nm, " rd_data"}, rdv, exp_rd);
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (o_busy[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("d%0d idle wait", d), 32'(o_busy[d]), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int last, nacks;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #2 rst = 1'b0;

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("reset ack",  32'(o_ack[0]),  32'h0);
      chk("reset err",  32'(o_err[0]),  32'h0);
      chk("reset busy", 32'(o_busy[0]), 32'h0);
      chk("reset rd",   o_rd[0],        32'h0);
      chk("reset rd1",  o_rd[1],        32'h0);
    end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post-reset busy", 32'(o_busy[0]), 32'h0);
    end

    for (int i = 0; i < 16; i++) begin
      req_chk("init0", 0, 1'b0, 1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i), 1'b0, 1'b0, 32'h0);
      req_chk("init1", 1, 1'b0, 1'b1, 32'(i * 4), 32'h5A00_0000 | 32'(i), 1'b0, 1'b0, 32'h0);
    end

    req_chk("wr 0x10", 0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    req_chk("rd 0x10", 0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    req_chk("rd 0x13", 0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b1, 1'b1, 32'h0);
    req_chk("wr oob", 0, 1'b0, 1'b1, 32'(D0 * 4), 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
    req_chk("rd w0", 0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA500_0000);
    req_chk("rd+wr", 0, 1'b1, 1'b1, 32'h8, 32'h1111_2222, 1'b1, 1'b1, 32'h0);
    req_chk("rd w2 unchanged", 0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, 32'hA500_0002);
    req_chk("wr w2", 0, 1'b0, 1'b1, 32'h8, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0);
    req_chk("raw w2", 0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, 32'h0BAD_F00D);

    // Held request: acceptances every L0+1 edges, first ack in loop slot 3.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    last = -1; nacks = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (o_ack[0]) begin
        if (last >= 0) chk("held spacing", 32'(c - last), 32'(L0 + 1));
        else chk("held first ack slot", 32'(c), 32'(L0 - 1));
        chk("held rd_data", o_rd[0], 32'hDEAD_BEEF);
        last = c; nacks++;
      end
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("held ack count", 32'(nacks), 32'd6);
    wait_idle(0);

    last = -1; nacks = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (o_ack[0]) begin
        if (last >= 0) chk("toggle spacing ok", 32'(c - last >= L0 + 1), 32'h1);
        last = c; nacks++;
      end
      drive(0, c[0] == 1'b0, 1'b0, 32'h14, 32'h0);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("toggle some acks", 32'(nacks >= 4), 32'h1);
    wait_idle(0);
    @(negedge clk);

    // Reset two edges into a write: no ack, write dropped.
    drive(0, 1'b0, 1'b1, 32'h20, 32'h0000_1234);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("midrst busy", 32'(o_busy[0]), 32'h1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst ack", 32'(o_ack[0]), 32'h0);
    chk("midrst busy low", 32'(o_busy[0]), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    nacks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (o_ack[0]) nacks++;
    end
    chk("midrst no ack", 32'(nacks), 32'h0);
    req_chk("rd 0x20 after rst", 0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'hA500_0008);

    req_chk("l1 rd 0x10", 1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h5A00_0004);
    req_chk("l1 rd oob", 1, 1'b1, 1'b0, 32'(D1 * 4), 32'h0, 1'b1, 1'b1, 32'h0);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h14, 32'h0);
    last = -1; nacks = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (o_ack[1]) begin
        if (last >= 0) chk("l1 spacing", 32'(c - last), 32'd2);
        chk("l1 rd_data", o_rd[1], 32'h5A00_0005);
        last = c; nacks++;
      end
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("l1 ack count", 32'(nacks), 32'd6);
    wait_idle(1);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        int r, s;
        logic [31:0] a;
        r = int'($urandom_range(0, 99));
        s = int'($urandom_range(0, 9));
        if (s < 8)       a = 32'($urandom_range(0, 15) * 4);
        else if (s == 8) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        else             a = 32'(DEPTHS[d] * 4) + 32'($urandom_range(0, 15) * 4);
        drive(d, r < 30, (r >= 25) && (r < 55), a, $urandom);
      end
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder that services single-word read/write requests from a core-side initiator. Each accepted request gets exactly one `ack` pulse after a fixed, parameterised latency. It backs a small word-addressed storage array and flags bad requests with `err`. The block is built as a two-level hierarchy (control wrapper plus storage sub-module) so the timing tooling can trace register-to-register paths across module boundaries.

## Interface

Parameters:
- `DEPTH_WORDS`, 256: number of 32-bit words. Must be a power of two and ≥ 2.
- `LATENCY`, 4: cycles from request acceptance to `ack`. Must be ≥ 1.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rd_req`  in  1  read request. Sampled only in IDLE.
- `wr_req`  in  1  write request. Sampled only in IDLE.
- `addr`  in  32  byte address. Must be word-aligned.
- `wr_data`  in  32  write data. Captured at acceptance.
- `ack`  out  1  one-cycle response strobe.
- `rd_data`  out  32  read data. Valid in the `ack` cycle; holds its value otherwise.
- `err`  out  1  asserted only together with `ack` when the request was invalid.
- `busy`  out  1  high from the cycle after acceptance through the `ack` cycle.

## Operation

- States: IDLE, WAIT, RESP. Reset forces IDLE.
- Reset values: `ack`=0, `err`=0, `busy`=0, `rd_data`=0, internal counter=0, captured addr/data=0.
- Storage contents are not reset.
- **IDLE:**
  - `rd_req | wr_req` high at a rising edge → request accepted at that edge.
  - Captures `addr`, `wr_data`, request type, and an error flag.
  - Next state is WAIT if `LATENCY` > 1, else RESP.
- **Error flag:** set if any of the following hold:
  - `addr[1:0]` ≠ 0;
  - `addr` ≥ `DEPTH_WORDS`*4;
  - `rd_req` and `wr_req` are both high.
- **WAIT:**
  - Counter loads `LATENCY`-2 at acceptance and decrements each cycle.
  - At 0 → RESP.
- **RESP:** lasts one cycle.
  - `ack`=1.
  - Error case: `err`=1, `rd_data`=0, no storage write.
  - Otherwise, read: `rd_data` = mem[`addr[log2(DEPTH_WORDS)+1:2]`].
  - Otherwise, write: the storage word is updated at the end of the RESP cycle, and `rd_data` is unchanged.
  - Next state is IDLE.
- Requests presented while not in IDLE are ignored, not queued. The initiator must wait for `ack`.
- A request held high through the RESP→IDLE edge is not accepted at that edge. It is sampled at the following edge.
- A read of a word written by the immediately preceding request returns the new data.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. A pending write is dropped and no `ack` is produced.

## Timing

- Request accepted at edge E0. `ack`, `err` and `rd_data` are registered and become valid in the cycle after edge E0+(`LATENCY`-1), i.e. `LATENCY` cycles after E0.
- `busy` rises after E0 and falls after the `ack` cycle.
- With `LATENCY`=1: `ack` appears the cycle after acceptance, and `busy` is high only in that cycle.
- Minimum spacing between accepted requests is `LATENCY`+1 edges, so throughput is 1/(`LATENCY`+1).
- `rd_data` path: register → sync-read array → output register. There is no combinational path from any input to any output.

## Structure

- Package `mem_responder_pkg`:
  - state enum `{IDLE, WAIT, RESP}`;
  - `WORD_BYTES`=4;
  - data width constant 32.
- Sub-module `mem_responder_array`:
  - single-port word array, one write port, registered read;
  - ports `clk`, `we`, `idx`, `wdata`, `rdata`.
- Top level `mem_responder` holds the FSM, counter, capture registers and error check, and instantiates the array once.

## Test plan

- **Reset:** hold `rst`=0 for 3 cycles → `ack`, `err`, `busy`, `rd_data` all 0. Release → `busy` stays 0 with no request.
- **Write then read:** `LATENCY`=4, write 0xDEADBEEF to 0x10 → `ack` exactly 4 cycles after acceptance with `err`=0. Read 0x10 → `ack` after 4 cycles with `rd_data`=0xDEADBEEF.
- **Errors:**
  - read 0x13 → `ack`=`err`=1, `rd_data`=0;
  - write to `DEPTH_WORDS`*4 → `err`=1, and a subsequent read of word 0 is unchanged;
  - `rd_req` and `wr_req` both high → `err`=1.
- **Ignored requests:** toggle `rd_req` every cycle while `busy` → exactly one `ack` per accepted request, with accepted requests spaced `LATENCY`+1 edges apart.
- **Mid-operation reset:** assert `rst` 2 cycles after accepting a write of 0x1234 to 0x20 → no `ack`. After reset, read 0x20 → does not return 0x1234 (it returns the value held before the write).
- **`LATENCY`=1 build:** back-to-back read requests held high → `ack` every second cycle with correct data.
